// File: rtl/led_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//   Shared types and constants for the LED frame scheduler slice.
//   - COLOR_W / NUM_LEDS_DEF : one GRB pixel is 24 bits, default strip is 6 LEDs
//   - frame_t                : one full default-size frame
//   - sched_state_t          : scheduler FSM states
//   - src_t                  : frame source identifiers
//   - other_src()            : the source that is not the given one
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int COLOR_W      = 24;
  localparam int NUM_LEDS_DEF = 6;

  typedef logic [NUM_LEDS_DEF*COLOR_W-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    LATCH
  } sched_state_t;

  typedef enum logic {
    SRC_A,
    SRC_B
  } src_t;

  function automatic src_t other_src(input src_t s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// led_rr_arb2
//   Two-requester round-robin arbiter, purely combinational. A lone requester
//   always wins; on a tie the source that did not win last time wins.
//   Ports:
//     req_a, req_b : request levels
//     last_grant   : previous winner (registered by the caller)
//     winner       : selected source, meaningful only when valid=1
//     valid        : at least one request present
// ---------------------------------------------------------------------------
module led_rr_arb2
  import led_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  src_t last_grant,
  output src_t winner,
  output logic valid
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    winner = SRC_A;
    valid  = req_a | req_b;
    if (req_a && req_b) begin
      winner = other_src(last_grant);
    end else if (req_b) begin
      winner = SRC_B;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
//   Shares one WS2812 led_driver between two frame sources. Captures the
//   round-robin winner's frame, pulses load, waits for drv_done, then holds
//   the line idle for LATCH_CYCLES so the strip latches before the next frame.
//
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     req_a / frame_a  : source A request level and frame; gnt_a pulses on capture
//     req_b / frame_b  : source B request level and frame; gnt_b pulses on capture
//     color_string     : captured frame presented to led_driver
//     load             : one-cycle start pulse to led_driver
//     drv_done         : led_driver finished shifting the frame
//     busy             : scheduler not in IDLE
//     frame_count      : frames completed (wraps)
//     err              : sticky watchdog timeout flag
//
//   Optional feature: define LED_FRAME_SCHED_WDT_EN to add a WAIT_DONE
//   watchdog of WDT_CYCLES cycles. Without it, err is constant 0 and the
//   scheduler waits for drv_done indefinitely.
// ---------------------------------------------------------------------------
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NUM_LEDS     = NUM_LEDS_DEF,
  parameter int LATCH_CYCLES = 4000,
  parameter int WDT_CYCLES   = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_a,
  input  logic [NUM_LEDS*COLOR_W-1:0] frame_a,
  output logic                        gnt_a,
  input  logic                        req_b,
  input  logic [NUM_LEDS*COLOR_W-1:0] frame_b,
  output logic                        gnt_b,
  output logic [NUM_LEDS*COLOR_W-1:0] color_string,
  output logic                        load,
  input  logic                        drv_done,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic                        err
);

  localparam int FRAME_W = NUM_LEDS * COLOR_W;
  localparam int LATCH_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LATCH_W-1:0] LATCH_INIT = LATCH_W'(LATCH_CYCLES - 1);

  sched_state_t        state_q,      state_d;
  logic [FRAME_W-1:0]  color_q,      color_d;
  logic                load_q,       load_d;
  logic                gnt_a_q,      gnt_a_d;
  logic                gnt_b_q,      gnt_b_d;
  logic                busy_q,       busy_d;
  logic [15:0]         frame_cnt_q,  frame_cnt_d;
  logic [LATCH_W-1:0]  latch_cnt_q,  latch_cnt_d;
  src_t                last_grant_q, last_grant_d;

`ifdef LED_FRAME_SCHED_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_CYCLES - 1);
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        err_q,     err_d;
`endif

  src_t arb_winner;
  logic arb_valid;

  led_rr_arb2 u_arb (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant_q),
    .winner     (arb_winner),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    load_d       = 1'b0;
    gnt_a_d      = 1'b0;
    gnt_b_d      = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    latch_cnt_d  = latch_cnt_q;
    last_grant_d = last_grant_q;
`ifdef LED_FRAME_SCHED_WDT_EN
    wdt_cnt_d    = wdt_cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        // load/gnt are registered, so raising them here makes them visible
        // exactly in the LOAD cycle, one cycle after the request is sampled.
        if (arb_valid) begin
          state_d      = LOAD;
          load_d       = 1'b1;
          last_grant_d = arb_winner;
          if (arb_winner == SRC_A) begin
            gnt_a_d = 1'b1;
            color_d = frame_a;
          end else begin
            gnt_b_d = 1'b1;
            color_d = frame_b;
          end
        end
      end

      LOAD: begin
        // drv_done is not looked at here: a done left over from the previous
        // frame must not complete this one.
        state_d = WAIT_DONE;
`ifdef LED_FRAME_SCHED_WDT_EN
        wdt_cnt_d = '0;
`endif
      end

      WAIT_DONE: begin
        if (drv_done) begin
          state_d     = LATCH;
          latch_cnt_d = LATCH_INIT;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
`ifdef LED_FRAME_SCHED_WDT_EN
        else if (wdt_cnt_q == WDT_LAST) begin
          // Timed-out frame: give the strip its latch gap but do not count it.
          state_d     = LATCH;
          latch_cnt_d = LATCH_INIT;
          err_d       = 1'b1;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 16'd1;
        end
`endif
      end

      LATCH: begin
        if (latch_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q - LATCH_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // busy is registered alongside state so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      color_q      <= '0;
      load_q       <= 1'b0;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= '0;
      latch_cnt_q  <= '0;
      last_grant_q <= SRC_B;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      load_q       <= load_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
      latch_cnt_q  <= latch_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef LED_FRAME_SCHED_WDT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign color_string = color_q;
  assign load         = load_q;
  assign gnt_a        = gnt_a_q;
  assign gnt_b        = gnt_b_q;
  assign busy         = busy_q;
  assign frame_count  = frame_cnt_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
//   Directed bench for led_frame_scheduler with LATCH_CYCLES=8 and
//   WDT_CYCLES=50. Inputs change 1 ns after the rising edge; outputs are
//   sampled at the same point, so each tick() shows the result of one edge.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;

  localparam int FW = 144;
  localparam logic [FW-1:0] FA = {{3{24'h00CEFF}}, {3{24'h7F32A8}}};
  localparam logic [FW-1:0] FB = {24'h112233, 24'h445566, 24'h778899,
                                  24'hAABBCC, 24'hDDEEFF, 24'h0F1E2D};

  logic          clk;
  logic          rst;
  logic          req_a, req_b;
  logic [FW-1:0] frame_a, frame_b;
  logic          gnt_a, gnt_b;
  logic [FW-1:0] color_string;
  logic          load;
  logic          drv_done;
  logic          busy;
  logic [15:0]   frame_count;
  logic          err;

  int total = 0;
  int bad   = 0;

  led_frame_scheduler #(
    .NUM_LEDS     (6),
    .LATCH_CYCLES (8),
    .WDT_CYCLES   (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_a        (req_a),
    .frame_a      (frame_a),
    .gnt_a        (gnt_a),
    .req_b        (req_b),
    .frame_b      (frame_b),
    .gnt_b        (gnt_b),
    .color_string (color_string),
    .load         (load),
    .drv_done     (drv_done),
    .busy         (busy),
    .frame_count  (frame_count),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FW-1:0] got,
                       input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until load is seen, at most 40 cycles.
  task automatic wait_load();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (load === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("load_seen", seen, 1'b1);
  endtask

  // Advance until busy drops, at most 40 cycles.
  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("idle_seen", seen, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; drv_done = 1'b0;
    frame_a = FA; frame_b = FB;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_color", color_string, '0);
    check("rst_load",  load,  1'b0);
    check("rst_gnt_a", gnt_a, 1'b0);
    check("rst_gnt_b", gnt_b, 1'b0);
    check("rst_busy",  busy,  1'b0);
    check("rst_fcnt",  frame_count, 16'd0);
    check("rst_err",   err,   1'b0);

    rst = 1'b0;
    tick();

    // First frame: A alone, load and gnt one cycle after the request is sampled
    req_a = 1'b1;
    tick();
    check("f1_load",  load,  1'b1);
    check("f1_gnt_a", gnt_a, 1'b1);
    check("f1_gnt_b", gnt_b, 1'b0);
    check("f1_color", color_string, FA);
    check("f1_busy",  busy,  1'b1);
    req_a = 1'b0;
    tick();
    check("f1_load_low",  load,  1'b0);
    check("f1_gnt_low",   gnt_a, 1'b0);
    check("f1_wait_busy", busy,  1'b1);
    check("f1_wait_fcnt", frame_count, 16'd0);

    // drv_done pulse; LATCH must last exactly 8 cycles
    repeat (18) tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("latch_busy", busy, 1'b1);
      check("latch_fcnt", frame_count, 16'd1);
      tick();
    end
    check("latch_end_busy", busy, 1'b0);
    check("latch_end_color", color_string, FA);

    // B alone, then asynchronous reset in WAIT_DONE
    req_b = 1'b1;
    wait_load();
    check("b_gnt_b", gnt_b, 1'b1);
    check("b_gnt_a", gnt_a, 1'b0);
    check("b_color", color_string, FB);
    req_b = 1'b0;
    tick();
    check("b_wait_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",  busy, 1'b0);
    check("arst_color", color_string, '0);
    check("arst_fcnt",  frame_count, 16'd0);
    check("arst_load",  load, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Both requesting: A wins the first tie after reset, then alternate
    req_a = 1'b1;
    req_b = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_load();
      check("rr_gnt_a", gnt_a, (f % 2) == 0);
      check("rr_gnt_b", gnt_b, (f % 2) == 1);
      check("rr_color", color_string, ((f % 2) == 0) ? FA : FB);
      tick();
      drv_done = 1'b1;
      tick();
      drv_done = 1'b0;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check("rr_fcnt", frame_count, 16'd4);
    wait_idle();

    // drv_done held high: ignored in LOAD, LATCH and IDLE
    req_a = 1'b1;
    wait_load();
    req_a = 1'b0;
    drv_done = 1'b1;
    tick();
    check("hd_load_ignored_busy", busy, 1'b1);
    check("hd_load_ignored_fcnt", frame_count, 16'd4);
    tick();
    check("hd_done_fcnt", frame_count, 16'd5);
    repeat (12) tick();
    check("hd_idle_busy", busy, 1'b0);
    check("hd_idle_fcnt", frame_count, 16'd5);
    req_a = 1'b1;
    wait_load();
    check("hd2_load_fcnt", frame_count, 16'd5);
    req_a = 1'b0;
    tick();
    check("hd2_wait_busy", busy, 1'b1);
    check("hd2_wait_fcnt", frame_count, 16'd5);
    tick();
    check("hd2_done_fcnt", frame_count, 16'd6);
    drv_done = 1'b0;
    wait_idle();

    // No drv_done at all
    req_b = 1'b1;
    wait_load();
    req_b = 1'b0;
    tick();
`ifdef LED_FRAME_SCHED_WDT_EN
    repeat (49) tick();
    check("wdt_pre_err", err, 1'b0);
    tick();
    check("wdt_err",  err,  1'b1);
    check("wdt_busy", busy, 1'b1);
    check("wdt_fcnt", frame_count, 16'd6);
    wait_idle();
    req_a = 1'b1;
    wait_load();
    req_a = 1'b0;
    tick();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    check("wdt_good_fcnt", frame_count, 16'd7);
    check("wdt_err_sticky", err, 1'b1);
    wait_idle();
    check("wdt_err_sticky_idle", err, 1'b1);
`else
    repeat (60) tick();
    check("nowdt_busy", busy, 1'b1);
    check("nowdt_err",  err,  1'b0);
    check("nowdt_fcnt", frame_count, 16'd6);
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
    check("nowdt_done_fcnt", frame_count, 16'd7);
    wait_idle();
    check("nowdt_err_end", err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
